// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: Start in IDLE is taken on the next Clk edge, and Tx/Busy/TxDone are registered.
// Start arriving while Busy is dropped, not queued; tick paces each bit (OVERSAMPLE ticks per bit).
module uart_tx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 tick,
   input  logic                 Start,
   input  logic [DATA_BITS-1:0] Data,
   output logic                 Tx,
   output logic                 Busy,
   output logic                 TxDone
);
   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   // DATA_BITS >= 5 keeps this wide enough for the stop-bit index too
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   assign bit_end = tick && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (state_q != IDLE && tick) begin
         cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      end
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (Start) begin
               shift_d = Data;
               par_d   = (^Data) ^ (PARITY_ODD != 0);
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q != DATA_LAST) begin
                  tx_d    = shift_q[1];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BW'(1);
               end else if (PARITY_EN != 0) begin
                  tx_d    = par_q;
                  state_d = PARITY;
               end else begin
                  tx_d    = 1'b1;
                  bit_d   = '0;
                  state_d = STOP;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               bit_d   = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q != STOP_LAST) begin
                  bit_d = bit_q + BW'(1);
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Tx     = tx_q;
   assign Busy   = busy_q;
   assign TxDone = done_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover default, even/odd parity and 7-bit/2-stop/OS4 framing.
module tb_uart_tx_param;
   logic       Clk;
   logic       Rst;
   logic       tick;
   logic [8:0] data_b;
   logic [3:0] start_v;
   logic [3:0] tx_v;
   logic [3:0] busy_v;
   logic [3:0] done_v;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         dut;
      logic [8:0] data;
      logic [11:0] exp;   // bit k = expected Tx during frame bit period k
      int         nbits;
      int         os;
      int         tper;
      int         mid_start;
   } vec_t;

   vec_t vecs[10];

   uart_tx_param u0 (
      .Clk(Clk), .Rst(Rst), .tick(tick), .Start(start_v[0]), .Data(data_b[7:0]),
      .Tx(tx_v[0]), .Busy(busy_v[0]), .TxDone(done_v[0]));
   uart_tx_param #(.PARITY_EN(1)) u1 (
      .Clk(Clk), .Rst(Rst), .tick(tick), .Start(start_v[1]), .Data(data_b[7:0]),
      .Tx(tx_v[1]), .Busy(busy_v[1]), .TxDone(done_v[1]));
   uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
      .Clk(Clk), .Rst(Rst), .tick(tick), .Start(start_v[2]), .Data(data_b[7:0]),
      .Tx(tx_v[2]), .Busy(busy_v[2]), .TxDone(done_v[2]));
   uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(4)) u3 (
      .Clk(Clk), .Rst(Rst), .tick(tick), .Start(start_v[3]), .Data(data_b[6:0]),
      .Tx(tx_v[3]), .Busy(busy_v[3]), .TxDone(done_v[3]));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   d, len, bad_tx, bad_busy, done_at, ndone;
      logic exp_tx, exp_busy;
      d        = v.dut;
      len      = v.nbits * v.os * v.tper;
      bad_tx   = -1;
      bad_busy = -1;
      done_at  = -1;
      ndone    = 0;
      @(negedge Clk);
      tick       = 1'b0;
      data_b     = v.data;
      start_v[d] = 1'b1;
      @(posedge Clk);
      #1;
      check($sformatf("v%0d_accept_tx", idx), int'(tx_v[d]), 0);
      check($sformatf("v%0d_accept_busy", idx), int'(busy_v[d]), 1);
      for (int c = 1; c <= len + 4; c++) begin
         @(negedge Clk);
         start_v[d] = (c == v.mid_start);
         data_b     = (c == v.mid_start) ? 9'h1FF : ~v.data;
         tick       = ((c % v.tper) == 0);
         @(posedge Clk);
         #1;
         if (c < len) begin
            exp_tx   = v.exp[(c / v.tper) / v.os];
            exp_busy = 1'b1;
         end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
         end
         if (tx_v[d] !== exp_tx && bad_tx < 0) bad_tx = c;
         if (busy_v[d] !== exp_busy && bad_busy < 0) bad_busy = c;
         if (done_v[d] === 1'b1) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
      end
      start_v[d] = 1'b0;
      tick       = 1'b0;
      check($sformatf("v%0d_tx_first_bad_cycle", idx), bad_tx, -1);
      check($sformatf("v%0d_busy_first_bad_cycle", idx), bad_busy, -1);
      check($sformatf("v%0d_txdone_cycle", idx), done_at, len);
      check($sformatf("v%0d_txdone_count", idx), ndone, 1);
   endtask

   initial begin
      int   bad, d1, d2;
      logic tx40, busy40, tx41, busy41, done41;
      vec_t va5;

      vecs[0] = '{0, 9'h055, 12'b0010_1010_1010, 10, 16, 1, 0};
      vecs[1] = '{0, 9'h000, 12'b0010_0000_0000, 10, 16, 1, 0};
      vecs[2] = '{0, 9'h0FF, 12'b0011_1111_1110, 10, 16, 1, 0};
      vecs[3] = '{0, 9'h03C, 12'b0010_0111_1000, 10, 16, 1, 50};
      vecs[4] = '{1, 9'h007, 12'b0110_0000_1110, 11, 16, 1, 0};
      vecs[5] = '{2, 9'h007, 12'b0100_0000_1110, 11, 16, 1, 0};
      vecs[6] = '{1, 9'h003, 12'b0100_0000_0110, 11, 16, 1, 0};
      vecs[7] = '{2, 9'h003, 12'b0110_0000_0110, 11, 16, 1, 0};
      vecs[8] = '{3, 9'h041, 12'b0011_1000_0010, 10, 4, 3, 0};
      vecs[9] = '{0, 9'h096, 12'b0011_0010_1100, 10, 16, 2, 0};
      va5     = '{0, 9'h0A5, 12'b0011_0100_1010, 10, 16, 1, 0};

      Rst     = 1'b1;
      tick    = 1'b0;
      data_b  = '0;
      start_v = '0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset_tx%0d", i), int'(tx_v[i]), 1);
         check($sformatf("reset_busy%0d", i), int'(busy_v[i]), 0);
         check($sformatf("reset_done%0d", i), int'(done_v[i]), 0);
      end
      repeat (3) @(negedge Clk);
      Rst = 1'b0;

      // ticks with no Start must leave every instance idle
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         tick = 1'b1;
         @(posedge Clk);
         #1;
         if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) bad++;
      end
      tick = 1'b0;
      check("idle_ticks_bad_cycles", bad, 0);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Start held high: frames separated by exactly one idle cycle
      @(negedge Clk);
      data_b     = 9'h041;
      start_v[3] = 1'b1;
      tick       = 1'b1;
      @(posedge Clk);
      #1;
      d1 = -1; d2 = -1;
      tx40 = 1'b0; busy40 = 1'b1; tx41 = 1'b1; busy41 = 1'b0; done41 = 1'b1;
      for (int c = 1; c <= 81; c++) begin
         @(posedge Clk);
         #1;
         if (done_v[3] === 1'b1) begin
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
         if (c == 40) begin tx40 = tx_v[3]; busy40 = busy_v[3]; end
         if (c == 41) begin tx41 = tx_v[3]; busy41 = busy_v[3]; done41 = done_v[3]; end
      end
      @(negedge Clk);
      start_v[3] = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      tick = 1'b0;
      check("b2b_first_done", d1, 40);
      check("b2b_second_done", d2, 81);
      check("b2b_gap_tx", int'(tx40), 1);
      check("b2b_gap_busy", int'(busy40), 0);
      check("b2b_restart_tx", int'(tx41), 0);
      check("b2b_restart_busy", int'(busy41), 1);
      check("b2b_restart_done", int'(done41), 0);
      check("b2b_no_third_frame", int'(busy_v[3]), 0);

      // reset during frame bit 3 of an all-zero payload
      @(negedge Clk);
      data_b     = 9'h000;
      start_v[0] = 1'b1;
      tick       = 1'b1;
      @(negedge Clk);
      start_v[0] = 1'b0;
      repeat (59) @(posedge Clk);
      #1;
      check("rst_pre_tx", int'(tx_v[0]), 0);
      check("rst_pre_busy", int'(busy_v[0]), 1);
      #2;
      Rst = 1'b1;
      #1;
      check("rst_async_tx", int'(tx_v[0]), 1);
      check("rst_async_busy", int'(busy_v[0]), 0);
      check("rst_async_done", int'(done_v[0]), 0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge Clk);
         #1;
         if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
      end
      tick = 1'b0;
      check("rst_abort_quiet_cycles", bad, 0);
      run_vec(10, va5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
